ula_matriz: RTL and testbench

Sequential matrix arithmetic unit sitting directly downstream of `gerencia_matriz`. It consumes the two packed operand matrices (`matriz1`, `matriz2`), the operation code and the matrix size, and computes one result element per step. It writes the packed `matriz_resultante` that the top level displays, then pulses `done`.

---
 rtl/ula_matriz_pkg.sv | 28 ++
 rtl/ula_sat.sv | 31 +++
 rtl/ula_matriz.sv | 156 +++++++++++++++
 tb/tb_ula_matriz.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ula_matriz_pkg.sv
// Shared definitions for the sequential matrix ALU: opcodes, sizes,
// FSM encoding and the element-index to bit-offset mapping.
package ula_matriz_pkg;

  localparam int ELEM_W = 9;
  localparam int N_MAX  = 5;
  localparam int BUS_W  = N_MAX * N_MAX * ELEM_W;
  localparam int ACC_W  = 21;

  localparam logic [2:0] OP_SOMA    = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_MULT    = 3'b010;
  localparam logic [2:0] OP_ESCALAR = 3'b011;
  localparam logic [2:0] OP_TRANSP  = 3'b100;
  localparam logic [2:0] OP_OPOSTA  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIM  = 2'd2
  } estado_t;

  // Bit offset of element (i,j) inside a packed N_MAX x N_MAX bus
  function automatic logic [7:0] elem_off(input logic [2:0] i, input logic [2:0] j);
    return 8'((int'(i) * N_MAX + int'(j)) * ELEM_W);
  endfunction

endpackage

// File: rtl/ula_sat.sv
// Range reduction of a wide signed result to ELEM_W bits.
// ULA_SATURATE_EN defined: clamp to the ELEM_W signed limits.
// ULA_SATURATE_EN undefined: keep the low ELEM_W bits (wrap).
// Either way ovf flags a value outside the ELEM_W range.
module ula_sat
  import ula_matriz_pkg::*;
(
  input  logic signed [ACC_W-1:0]  valor,
  output logic        [ELEM_W-1:0] resultado,
  output logic                     ovf
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 <<< (ELEM_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = -MAX_V - ACC_W'(1);

  // Detect out-of-range and produce the reduced element
  always_comb begin
    ovf = (valor > MAX_V) || (valor < MIN_V);
`ifdef ULA_SATURATE_EN
    if (valor > MAX_V)
      resultado = MAX_V[ELEM_W-1:0];
    else if (valor < MIN_V)
      resultado = MIN_V[ELEM_W-1:0];
    else
      resultado = valor[ELEM_W-1:0];
`else
    resultado = valor[ELEM_W-1:0];
`endif
  end

endmodule

// File: rtl/ula_matriz.sv
// Sequential matrix ALU: one result element (or one MAC for the matrix
// product) per cycle, row-major scan, done pulse at the end.
// Range behaviour selected by ULA_SATURATE_EN (see ula_sat).
//
// state | meaning
// IDLE  | waiting for start; start sampled here only
// CALC  | scanning elements / MAC steps
// FIM   | done pulse (also the error response for invalid requests)
module ula_matriz
  import ula_matriz_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       operacao,
  input  logic [4:0]       tamanho,
  input  logic [BUS_W-1:0] matriz1,
  input  logic [BUS_W-1:0] matriz2,
  output logic [BUS_W-1:0] matriz_resultante,
  output logic             busy,
  output logic             done,
  output logic             erro,
  output logic             overflow
);

  estado_t                  estado;
  logic [2:0]               op_r;
  logic [2:0]               n_r;
  logic [BUS_W-1:0]         a_r;
  logic [BUS_W-1:0]         b_r;
  logic [2:0]               i_r, j_r, k_r;
  logic signed [ACC_W-1:0]  acc_r;

  logic [2:0]               ult;
  logic                     valido;
  logic                     ult_k;
  logic signed [ELEM_W-1:0] a_ij, b_ij, a_ji, a_ik, b_kj, escalar;
  logic signed [2*ELEM_W-1:0] prod;
  logic signed [ACC_W-1:0]  ea, eb, et, ep, acc_next, valor;
  logic [ELEM_W-1:0]        sat_res;
  logic                     sat_ovf;

  assign ult     = n_r - 3'd1;
  assign valido  = (operacao <= OP_OPOSTA) && (tamanho >= 5'd1) && (tamanho <= 5'(N_MAX));
  assign ult_k   = (op_r != OP_MULT) || (k_r == ult);

  assign a_ij    = a_r[elem_off(i_r, j_r) +: ELEM_W];
  assign b_ij    = b_r[elem_off(i_r, j_r) +: ELEM_W];
  assign a_ji    = a_r[elem_off(j_r, i_r) +: ELEM_W];
  assign a_ik    = a_r[elem_off(i_r, k_r) +: ELEM_W];
  assign b_kj    = b_r[elem_off(k_r, j_r) +: ELEM_W];
  assign escalar = b_r[ELEM_W-1:0];

  // Datapath: widen operands, form the unreduced value for the current step
  always_comb begin
    if (op_r == OP_MULT)
      prod = a_ik * b_kj;
    else
      prod = a_ij * escalar;
    ea       = {{(ACC_W-ELEM_W){a_ij[ELEM_W-1]}}, a_ij};
    eb       = {{(ACC_W-ELEM_W){b_ij[ELEM_W-1]}}, b_ij};
    et       = {{(ACC_W-ELEM_W){a_ji[ELEM_W-1]}}, a_ji};
    ep       = {{(ACC_W-2*ELEM_W){prod[2*ELEM_W-1]}}, prod};
    acc_next = ((k_r == 3'd0) ? '0 : acc_r) + ep;
    case (op_r)
      OP_SOMA:    valor = ea + eb;
      OP_SUB:     valor = ea - eb;
      OP_MULT:    valor = acc_next;
      OP_ESCALAR: valor = ep;
      OP_TRANSP:  valor = et;
      OP_OPOSTA:  valor = -ea;
      default:    valor = ea;
    endcase
  end

  ula_sat u_sat (
    .valor     (valor),
    .resultado (sat_res),
    .ovf       (sat_ovf)
  );

  // Control FSM with registered outputs, operand latches and scan counters
  always_ff @(posedge clk) begin
    if (reset) begin
      estado            <= IDLE;
      op_r              <= '0;
      n_r               <= '0;
      a_r               <= '0;
      b_r               <= '0;
      i_r               <= '0;
      j_r               <= '0;
      k_r               <= '0;
      acc_r             <= '0;
      matriz_resultante <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      erro              <= 1'b0;
      overflow          <= 1'b0;
    end else begin
      case (estado)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            overflow <= 1'b0;
            if (valido) begin
              op_r              <= operacao;
              n_r               <= tamanho[2:0];
              a_r               <= matriz1;
              b_r               <= matriz2;
              i_r               <= '0;
              j_r               <= '0;
              k_r               <= '0;
              acc_r             <= '0;
              matriz_resultante <= '0;
              erro              <= 1'b0;
              estado            <= CALC;
            end else begin
              erro   <= 1'b1;
              done   <= 1'b1;
              estado <= FIM;
            end
          end
        end
        CALC: begin
          acc_r <= acc_next;
          if (ult_k) begin
            matriz_resultante[elem_off(i_r, j_r) +: ELEM_W] <= sat_res;
            overflow <= overflow | sat_ovf;
            k_r      <= '0;
            if (j_r == ult) begin
              j_r <= '0;
              if (i_r == ult) begin
                done   <= 1'b1;
                estado <= FIM;
              end else begin
                i_r <= i_r + 3'd1;
              end
            end else begin
              j_r <= j_r + 3'd1;
            end
          end else begin
            k_r <= k_r + 3'd1;
          end
        end
        FIM: begin
          done   <= 1'b0;
          busy   <= 1'b0;
          estado <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_matriz.sv
// Directed bench for ula_matriz: hand-computed results and done latencies.
module tb_ula_matriz;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   operacao;
  logic [4:0]   tamanho;
  logic [224:0] matriz1, matriz2, matriz_resultante;
  logic         busy, done, erro, overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ula_matriz dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .operacao          (operacao),
    .tamanho           (tamanho),
    .matriz1           (matriz1),
    .matriz2           (matriz2),
    .matriz_resultante (matriz_resultante),
    .busy              (busy),
    .done              (done),
    .erro              (erro),
    .overflow          (overflow)
  );

  task automatic chk(input string tag, input logic [224:0] obs, input logic [224:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [224:0] put(input logic [224:0] bus, input int i, input int j, input int v);
    logic [224:0] r;
    r = bus;
    r[(i*5+j)*9 +: 9] = 9'(v);
    return r;
  endfunction

  function automatic logic [224:0] mat2(input int a, input int b, input int c, input int d);
    logic [224:0] r;
    r = '0;
    r = put(r, 0, 0, a);
    r = put(r, 0, 1, b);
    r = put(r, 1, 0, c);
    r = put(r, 1, 1, d);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a start, then count cycles until done; poke>0 re-asserts start mid-run
  task automatic run_op(input logic [2:0] op, input logic [4:0] n, input int poke, output int dcyc);
    operacao = op;
    tamanho  = n;
    start    = 1'b1;
    step();
    start = 1'b0;
    dcyc  = -1;
    for (int c = 1; c <= 200; c++) begin
      if (done) begin
        dcyc = c;
        break;
      end
      if (c == poke) begin
        start    = 1'b1;
        operacao = 3'b000;
        matriz1  = '1;
      end
      step();
      start = 1'b0;
    end
  endtask

  task automatic fin(input string tag);
    chk({tag, "_busy_at_done"}, busy, 1'b1);
    step();
    chk({tag, "_busy_after"}, busy, 1'b0);
    chk({tag, "_done_after"}, done, 1'b0);
  endtask

  int           d;
  logic [224:0] exp_r;
  logic [224:0] prev;

  initial begin
    reset = 1'b1; start = 1'b0; operacao = '0; tamanho = '0;
    matriz1 = '0; matriz2 = '0;
    repeat (3) step();
    chk("rst_res", matriz_resultante, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_erro", erro, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    step();

    matriz1 = mat2(1, 2, 3, 4);
    matriz2 = mat2(5, 6, 7, 8);
    run_op(3'b000, 5'd2, 0, d);
    chk("soma_cyc", 225'(d), 225'(5));
    chk("soma_res", matriz_resultante, mat2(6, 8, 10, 12));
    chk("soma_ovf", overflow, 1'b0);
    chk("soma_erro", erro, 1'b0);
    fin("soma");

    run_op(3'b001, 5'd2, 0, d);
    chk("sub_cyc", 225'(d), 225'(5));
    chk("sub_res", matriz_resultante, mat2(-4, -4, -4, -4));
    fin("sub");

    run_op(3'b011, 5'd2, 0, d);
    chk("esc_cyc", 225'(d), 225'(5));
    chk("esc_res", matriz_resultante, mat2(5, 10, 15, 20));
    fin("esc");

    run_op(3'b010, 5'd2, 0, d);
    chk("mult_cyc", 225'(d), 225'(9));
    chk("mult_res", matriz_resultante, mat2(19, 22, 43, 50));
    chk("mult_ovf", overflow, 1'b0);
    fin("mult");

    matriz1 = '0; matriz2 = '0; exp_r = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        matriz1 = put(matriz1, i, j, 200);
        matriz2 = put(matriz2, i, j, 100);
`ifdef ULA_SATURATE_EN
        if (i < 3 && j < 3) exp_r = put(exp_r, i, j, 255);
`else
        if (i < 3 && j < 3) exp_r = put(exp_r, i, j, -212);
`endif
      end
    run_op(3'b000, 5'd3, 0, d);
    chk("ovf_cyc", 225'(d), 225'(10));
    chk("ovf_res", matriz_resultante, exp_r);
    chk("ovf_flag", overflow, 1'b1);
    fin("ovf");

    matriz1 = '0; exp_r = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        matriz1 = put(matriz1, i, j, i*5 + j);
        exp_r   = put(exp_r, i, j, j*5 + i);
      end
    run_op(3'b100, 5'd5, 10, d);
    chk("transp_cyc", 225'(d), 225'(26));
    chk("transp_res", matriz_resultante, exp_r);
    chk("transp_ovf", overflow, 1'b0);
    fin("transp");
    prev = exp_r;

    run_op(3'b110, 5'd2, 0, d);
    chk("inv_op_cyc", 225'(d), 225'(1));
    chk("inv_op_erro", erro, 1'b1);
    chk("inv_op_res", matriz_resultante, prev);
    fin("inv_op");

    run_op(3'b000, 5'd0, 0, d);
    chk("inv_n0_cyc", 225'(d), 225'(1));
    chk("inv_n0_erro", erro, 1'b1);
    chk("inv_n0_res", matriz_resultante, prev);
    fin("inv_n0");

    run_op(3'b000, 5'd6, 0, d);
    chk("inv_n6_cyc", 225'(d), 225'(1));
    chk("inv_n6_erro", erro, 1'b1);
    chk("inv_n6_res", matriz_resultante, prev);
    fin("inv_n6");

    // Product aborted by reset in cycle 40
    operacao = 3'b010; tamanho = 5'd5; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 40; c++) step();
    chk("abort_busy_c40", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_res", matriz_resultante, '0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_erro", erro, 1'b0);
    chk("abort_ovf", overflow, 1'b0);

    matriz1 = mat2(1, 2, 3, 4);
    run_op(3'b101, 5'd2, 0, d);
    chk("neg_cyc", 225'(d), 225'(5));
    chk("neg_res", matriz_resultante, mat2(-1, -2, -3, -4));
    fin("neg");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
